// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC and IR and runs the single outstanding
// instruction-memory read, with a watchdog that parks the FSM in FAULT.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int               TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_wren,
  input  logic             pc_inc,
  input  logic             pc_load,
  input  logic [WIDTH-1:0] pc_load_addr,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] ir,
  output logic [6:0]       opcode,
  output logic             fetch_busy,
  output logic             fetch_done,
  output logic             fault
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] NOP_INSN = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] PC_STEP  = WIDTH'(4);
  localparam logic [WIDTH-1:0] PC_INIT  = {RESET_PC[WIDTH-1:2], 2'b00};

  typedef enum logic [1:0] {IDLE, BUSY, FAULT} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [WIDTH-1:0] ir_reg, ir_next;
  logic [WIDTH-1:0] fetch_addr_reg, fetch_addr_next;
  logic             inc_pending_reg, inc_pending_next;
  logic [CW-1:0]    timeout_cnt_reg, timeout_cnt_next;
  logic             fetch_done_reg, fetch_done_next;
  logic [WIDTH-1:0] pc_plus4;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^pc_load_addr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      pc_reg          <= PC_INIT;
      ir_reg          <= NOP_INSN;
      fetch_addr_reg  <= '0;
      inc_pending_reg <= 1'b0;
      timeout_cnt_reg <= '0;
      fetch_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      ir_reg          <= ir_next;
      fetch_addr_reg  <= fetch_addr_next;
      inc_pending_reg <= inc_pending_next;
      timeout_cnt_reg <= timeout_cnt_next;
      fetch_done_reg  <= fetch_done_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    ir_next          = ir_reg;
    fetch_addr_next  = fetch_addr_reg;
    inc_pending_next = inc_pending_reg;
    timeout_cnt_next = timeout_cnt_reg;
    fetch_done_next  = 1'b0;
    pc_plus4         = pc_reg + PC_STEP;

    case (state_reg)
      IDLE: begin
        if (ir_wren) begin
          // The increment is deferred until the instruction is captured.
          fetch_addr_next  = pc_reg;
          inc_pending_next = pc_inc;
          timeout_cnt_next = '0;
          state_next       = BUSY;
        end else if (pc_inc) begin
          pc_next = pc_plus4;
        end
      end
      BUSY: begin
        if (imem_valid) begin
          ir_next          = imem_rdata;
          if (inc_pending_reg) pc_next = pc_plus4;
          inc_pending_next = 1'b0;
          fetch_done_next  = 1'b1;
          state_next       = IDLE;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + 1'b1;
          if (timeout_cnt_next == CW'(TIMEOUT)) state_next = FAULT;
        end
      end
      FAULT: begin
        if (pc_load) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A jump overrides any increment and cancels a deferred one, but the
    // in-flight fetch still completes from its original address.
    if (pc_load) begin
      pc_next          = {pc_load_addr[WIDTH-1:2], 2'b00};
      inc_pending_next = 1'b0;
    end
  end

  assign imem_req   = (state_reg == BUSY);
  assign fetch_busy = (state_reg == BUSY);
  assign fault      = (state_reg == FAULT);
  assign imem_addr  = fetch_addr_reg;
  assign pc         = pc_reg;
  assign ir         = ir_reg;
  assign opcode     = ir_reg[6:0];
  assign fetch_done = fetch_done_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change 1 time unit after the rising
// edge and outputs are checked there, before the next edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_wren, pc_inc, pc_load, imem_valid;
  logic [31:0] pc_load_addr, imem_rdata;
  logic        imem_req, fetch_busy, fetch_done, fault;
  logic [31:0] imem_addr, pc, ir;
  logic [6:0]  opcode;

  int n_compared   = 0;
  int n_mismatched = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst), .ir_wren(ir_wren), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .pc(pc), .ir(ir), .opcode(opcode),
    .fetch_busy(fetch_busy), .fetch_done(fetch_done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir_wren = 0; pc_inc = 0; pc_load = 0; imem_valid = 0;
  endtask

  initial begin
    rst = 1; idle_inputs(); pc_load_addr = '0; imem_rdata = '0;
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h13);
    check("rst_req", {31'b0, imem_req}, 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_done", {31'b0, fetch_done}, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);
    check("rst_busy", {31'b0, fetch_busy}, 32'h0);
    tick(); rst = 0;

    // Minimum-latency fetch with deferred increment
    ir_wren = 1; pc_inc = 1; tick();
    idle_inputs();
    check("f1_req", {31'b0, imem_req}, 32'h1);
    check("f1_busy", {31'b0, fetch_busy}, 32'h1);
    check("f1_pc_held", pc, 32'h0);
    imem_valid = 1; imem_rdata = 32'h0050_0093; tick();
    imem_valid = 0;
    check("f1_ir", ir, 32'h0050_0093);
    check("f1_opcode", {25'b0, opcode}, 32'h13);
    check("f1_pc", pc, 32'h4);
    check("f1_done", {31'b0, fetch_done}, 32'h1);
    check("f1_req_off", {31'b0, imem_req}, 32'h0);
    tick();
    check("f1_done_pulse", {31'b0, fetch_done}, 32'h0);

    // Fetch with three wait cycles
    ir_wren = 1; pc_inc = 1; tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("f2_req_w%0d", i), {31'b0, imem_req}, 32'h1);
      check($sformatf("f2_addr_w%0d", i), imem_addr, 32'h4);
      check($sformatf("f2_pc_w%0d", i), pc, 32'h4);
      tick();
    end
    check("f2_req_w3", {31'b0, imem_req}, 32'h1);
    imem_valid = 1; imem_rdata = 32'h0000_000A; tick();
    imem_valid = 0;
    check("f2_ir", ir, 32'h0000_000A);
    check("f2_pc", pc, 32'h8);
    check("f2_req_off", {31'b0, imem_req}, 32'h0);

    // Jump during a fetch: fetch completes from old address, no +4
    pc_load = 1; pc_load_addr = 32'h10; tick();
    pc_load = 0;
    check("j_pc10", pc, 32'h10);
    ir_wren = 1; pc_inc = 1; tick();
    idle_inputs();
    pc_load = 1; pc_load_addr = 32'h203; tick();
    pc_load = 0;
    check("j_pc_aligned", pc, 32'h200);
    check("j_req", {31'b0, imem_req}, 32'h1);
    check("j_addr", imem_addr, 32'h10);
    imem_valid = 1; imem_rdata = 32'h0001_2345; tick();
    imem_valid = 0;
    check("j_ir", ir, 32'h0001_2345);
    check("j_pc_noinc", pc, 32'h200);
    check("j_done", {31'b0, fetch_done}, 32'h1);

    // Timeout: 15 BUSY cycles without imem_valid
    ir_wren = 1; tick();
    idle_inputs();
    for (int i = 0; i < 14; i++) tick();
    check("to_req_14", {31'b0, imem_req}, 32'h1);
    check("to_fault_14", {31'b0, fault}, 32'h0);
    tick();
    check("to_fault", {31'b0, fault}, 32'h1);
    check("to_req_off", {31'b0, imem_req}, 32'h0);
    check("to_busy_off", {31'b0, fetch_busy}, 32'h0);
    ir_wren = 1; pc_inc = 1; imem_valid = 1; imem_rdata = 32'hBAD0_BAD0; tick();
    idle_inputs();
    check("to_ignore_pc", pc, 32'h200);
    check("to_ignore_ir", ir, 32'h0001_2345);
    check("to_sticky", {31'b0, fault}, 32'h1);
    pc_load = 1; pc_load_addr = 32'h100; tick();
    pc_load = 0;
    check("to_clear", {31'b0, fault}, 32'h0);
    check("to_idle", {31'b0, fetch_busy}, 32'h0);
    check("to_pc", pc, 32'h100);

    // Wraparound and load-over-increment priority
    pc_load = 1; pc_load_addr = 32'hFFFF_FFFC; tick();
    pc_load = 0;
    check("wr_pc_top", pc, 32'hFFFF_FFFC);
    pc_inc = 1; tick();
    pc_inc = 0;
    check("wr_pc_zero", pc, 32'h0);
    pc_inc = 1; pc_load = 1; pc_load_addr = 32'h40; tick();
    idle_inputs();
    check("prio_pc", pc, 32'h40);

    // Asynchronous reset mid-fetch
    ir_wren = 1; pc_inc = 1; tick();
    idle_inputs();
    check("ar_req_before", {31'b0, imem_req}, 32'h1);
    #2 rst = 1;
    #1;
    check("ar_req", {31'b0, imem_req}, 32'h0);
    check("ar_ir", ir, 32'h13);
    check("ar_pc", pc, 32'h0);
    check("ar_busy", {31'b0, fetch_busy}, 32'h0);
    tick(); rst = 0;
    imem_valid = 1; imem_rdata = 32'hDEAD_BEEF; tick();
    imem_valid = 0;
    check("ar_late_ir", ir, 32'h13);
    check("ar_late_done", {31'b0, fetch_done}, 32'h0);
    check("ar_late_pc", pc, 32'h0);
    tick();
    check("ar_late_done2", {31'b0, fetch_done}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
